// File: rtl/ace_arb_pkg.sv
// Shared types for the ACE request arbiter: opcode and FSM state encodings,
// plus a small cyclic-index helper used by the round-robin picker.
package ace_arb_pkg;

   typedef enum logic [1:0] {
      OP_NONE  = 2'b00,
      OP_READ  = 2'b01,
      OP_WRITE = 2'b10,
      OP_INVAL = 2'b11
   } ace_op_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } arb_state_t;

   // Index reached by stepping 'off' places from 'base' around a ring of n slots.
   function automatic int wrap_idx(input int base, input int off, input int n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request at or
// after ptr (cyclically) as a one-hot grant and as an index.
module rr_pick
   import ace_arb_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   // Scan the ring starting at ptr; the first hit wins.
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!any && req[wrap_idx(int'(ptr), k, N)]) begin
            any                              = 1'b1;
            gnt[wrap_idx(int'(ptr), k, N)]   = 1'b1;
            idx                              = IW'(wrap_idx(int'(ptr), k, N));
         end
      end
   end

endmodule

// File: rtl/ace_req_arbiter.sv
// Shares one ACE controller between NUM_REQ cache-side requesters.
// Picks a pending request round-robin, registers it, pulses one request
// strobe, waits for ace_ready and returns a one-cycle response.
// Optional build macro ACE_ARB_WB_PRIO_EN: eligible writers are served first.
//
// state | meaning
// IDLE  | looking for an eligible requester; req_ready is the accept strobe
// ISSUE | one of read_req/write_req/invalid_req is high for this cycle
// WAIT  | transaction in flight, waiting for ace_ready
// DONE  | resp_valid to the owner, round-robin pointer advances
module ace_req_arbiter
   import ace_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   localparam int GW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [2*NUM_REQ-1:0]      req_op,
   input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
   input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        resp_valid,
   output logic [DATA_W-1:0]         resp_rdata,
   output logic                      read_req,
   output logic                      write_req,
   output logic                      invalid_req,
   input  logic                      ace_ready,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata,
   output logic                      busy,
   output logic [GW-1:0]             grant_id
);

   arb_state_t         state;
   logic [GW-1:0]      rr_ptr;
   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] sel_gnt;
   logic [GW-1:0]      sel_idx;
   logic               sel_any;
   ace_op_t            sel_op;

   // A requester competes only with a real opcode attached.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         elig[i] = req_valid[i] && (ace_op_t'(req_op[2*i +: 2]) != OP_NONE);
      end
   end

`ifdef ACE_ARB_WB_PRIO_EN
   logic [NUM_REQ-1:0] wr_elig;
   logic [NUM_REQ-1:0] wr_gnt;
   logic [GW-1:0]      wr_idx;
   logic               wr_any;
   logic [NUM_REQ-1:0] all_gnt;
   logic [GW-1:0]      all_idx;
   logic               all_any;

   // Writers form their own ring so write-backs drain ahead of fills.
   always_comb begin
      wr_elig = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         wr_elig[i] = elig[i] && (ace_op_t'(req_op[2*i +: 2]) == OP_WRITE);
      end
   end

   rr_pick #(.N(NUM_REQ), .IW(GW)) u_pick_wr (
      .req (wr_elig),
      .ptr (rr_ptr),
      .gnt (wr_gnt),
      .idx (wr_idx),
      .any (wr_any)
   );

   rr_pick #(.N(NUM_REQ), .IW(GW)) u_pick_all (
      .req (elig),
      .ptr (rr_ptr),
      .gnt (all_gnt),
      .idx (all_idx),
      .any (all_any)
   );

   assign sel_gnt = wr_any ? wr_gnt : all_gnt;
   assign sel_idx = wr_any ? wr_idx : all_idx;
   assign sel_any = wr_any | all_any;
`else
   rr_pick #(.N(NUM_REQ), .IW(GW)) u_pick_all (
      .req (elig),
      .ptr (rr_ptr),
      .gnt (sel_gnt),
      .idx (sel_idx),
      .any (sel_any)
   );
`endif

   assign sel_op = ace_op_t'(req_op[int'(sel_idx)*2 +: 2]);

   // Accept strobe is combinational in IDLE; held low while reset is applied
   // so every output reads 0 during reset.
   assign req_ready = (state == IDLE && !rst) ? sel_gnt : '0;

   // Request FSM with registered strobes, capture registers and rr pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         grant_id    <= '0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         resp_rdata  <= '0;
         resp_valid  <= '0;
         read_req    <= 1'b0;
         write_req   <= 1'b0;
         invalid_req <= 1'b0;
         busy        <= 1'b0;
      end else begin
         read_req    <= 1'b0;
         write_req   <= 1'b0;
         invalid_req <= 1'b0;
         resp_valid  <= '0;
         case (state)
            IDLE: begin
               if (sel_any) begin
                  grant_id    <= sel_idx;
                  mem_addr    <= req_addr[int'(sel_idx)*ADDR_W +: ADDR_W];
                  mem_wdata   <= req_wdata[int'(sel_idx)*DATA_W +: DATA_W];
                  read_req    <= (sel_op == OP_READ);
                  write_req   <= (sel_op == OP_WRITE);
                  invalid_req <= (sel_op == OP_INVAL);
                  busy        <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               if (ace_ready) begin
                  resp_rdata <= mem_rdata;
                  resp_valid <= NUM_REQ'(1) << grant_id;
                  state      <= DONE;
               end
            end
            DONE: begin
               // With a single requester grant_id is always 0, so rr_ptr stays 0.
               rr_ptr <= (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // At most one request strobe and one accept strobe at a time.
   a_strobe_onehot: assert property (@(posedge clk) disable iff (rst)
      $onehot0({read_req, write_req, invalid_req}));
   a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
      $onehot0(req_ready));

endmodule

// File: tb/tb_ace_req_arbiter.sv
// Self-checking bench for ace_req_arbiter: a vector table of whole
// transactions, hand sequences for reset/withdrawal/noise/long waits, and a
// randomized phase checked against a reference arbitration model.
module tb_ace_req_arbiter;
   import ace_arb_pkg::*;

   localparam int NUM_REQ = 2;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int GW      = 1;

   logic                      clk;
   logic                      rst;
   logic [NUM_REQ-1:0]        req_valid;
   logic [2*NUM_REQ-1:0]      req_op;
   logic [ADDR_W*NUM_REQ-1:0] req_addr;
   logic [DATA_W*NUM_REQ-1:0] req_wdata;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        resp_valid;
   logic [DATA_W-1:0]         resp_rdata;
   logic                      read_req, write_req, invalid_req;
   logic                      ace_ready;
   logic [ADDR_W-1:0]         mem_addr;
   logic [DATA_W-1:0]         mem_wdata;
   logic [DATA_W-1:0]         mem_rdata;
   logic                      busy;
   logic [GW-1:0]             grant_id;

   logic              valid_a [NUM_REQ];
   ace_op_t           op_a    [NUM_REQ];
   logic [ADDR_W-1:0] addr_a  [NUM_REQ];
   logic [DATA_W-1:0] wdata_a [NUM_REQ];

   int total;
   int bad;
   int model_ptr;

   typedef struct {
      logic [1:0] v;
      ace_op_t    op0;
      ace_op_t    op1;
      int         g;
      ace_op_t    eop;
   } vec_t;

   vec_t tbl [8];

   ace_req_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_op      (req_op),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_ready   (req_ready),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .read_req    (read_req),
      .write_req   (write_req),
      .invalid_req (invalid_req),
      .ace_ready   (ace_ready),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .busy        (busy),
      .grant_id    (grant_id)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   always_comb begin
      req_valid = '0;
      req_op    = '0;
      req_addr  = '0;
      req_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i]                = valid_a[i];
         req_op[2*i +: 2]            = op_a[i];
         req_addr[ADDR_W*i +: ADDR_W] = addr_a[i];
         req_wdata[DATA_W*i +: DATA_W] = wdata_a[i];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [2:0] exp_strb(input ace_op_t op);
      case (op)
         OP_READ:  return 3'b100;
         OP_WRITE: return 3'b010;
         OP_INVAL: return 3'b001;
         default:  return 3'b000;
      endcase
   endfunction

   // Reference arbitration: smallest cyclic distance from the pointer among
   // the candidates; candidates are writers only when priority is built in
   // and some writer is eligible.
   function automatic int model_pick();
      int  best;
      int  bestd;
      int  d;
      bit  wr_only;
      best    = -1;
      bestd   = NUM_REQ;
      wr_only = 1'b0;
`ifdef ACE_ARB_WB_PRIO_EN
      for (int i = 0; i < NUM_REQ; i++)
         if (valid_a[i] && op_a[i] == OP_WRITE) wr_only = 1'b1;
`endif
      for (int i = 0; i < NUM_REQ; i++) begin
         if (valid_a[i] && op_a[i] != OP_NONE && (!wr_only || op_a[i] == OP_WRITE)) begin
            d = (i - model_ptr + NUM_REQ) % NUM_REQ;
            if (d < bestd) begin
               bestd = d;
               best  = i;
            end
         end
      end
      return best;
   endfunction

   task automatic set_req(input int i, input logic v, input ace_op_t op,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] w);
      valid_a[i] = v;
      op_a[i]    = op;
      addr_a[i]  = a;
      wdata_a[i] = w;
   endtask

   task automatic rand_req(input int i);
      set_req(i, 1'($urandom_range(0, 1)), ace_op_t'($urandom_range(0, 3)), $urandom, $urandom);
   endtask

   // One full transaction, entered at the start of an IDLE cycle with the
   // request inputs already driven; leaves at the start of the next IDLE cycle.
   task automatic txn(input int g, input ace_op_t op, input int wt,
                      input logic [DATA_W-1:0] rd, input bit spur,
                      input logic [NUM_REQ-1:0] drop_mask);
      logic [NUM_REQ-1:0] oh;
      oh = NUM_REQ'(1) << g;
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_resp", resp_valid, 0);
      chk("accept_ready", req_ready, oh);
      step();
      for (int i = 0; i < NUM_REQ; i++)
         if (drop_mask[i]) valid_a[i] = 1'b0;
      ace_ready = spur;
      #1;
      chk("issue_strobe", {read_req, write_req, invalid_req}, exp_strb(op));
      chk("issue_addr", mem_addr, addr_a[g]);
      chk("issue_wdata", mem_wdata, wdata_a[g]);
      chk("issue_gid", grant_id, g);
      chk("issue_ready", req_ready, 0);
      chk("issue_busy", busy, 1);
      ace_ready = 1'b0;
      for (int k = 0; k < wt; k++) begin
         step();
         #1;
         chk("wait_strobe", {read_req, write_req, invalid_req}, 0);
         chk("wait_resp", resp_valid, 0);
         chk("wait_busy", busy, 1);
      end
      step();
      ace_ready = 1'b1;
      mem_rdata = rd;
      step();
      ace_ready = spur;
      mem_rdata = $urandom;
      #1;
      chk("done_resp", resp_valid, oh);
      if (op == OP_READ) chk("done_rdata", resp_rdata, rd);
      chk("done_gid", grant_id, g);
      chk("done_addr", mem_addr, addr_a[g]);
      chk("done_busy", busy, 1);
      ace_ready = 1'b0;
      model_ptr = (g + 1) % NUM_REQ;
      step();
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_ready"}, req_ready, 0);
      chk({nm, "_resp"}, resp_valid, 0);
      chk({nm, "_rdata"}, resp_rdata, 0);
      chk({nm, "_strobe"}, {read_req, write_req, invalid_req}, 0);
      chk({nm, "_addr"}, mem_addr, 0);
      chk({nm, "_wdata"}, mem_wdata, 0);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_gid"}, grant_id, 0);
   endtask

   initial begin
      int g;
      total     = 0;
      bad       = 0;
      model_ptr = 0;
      rst       = 1'b1;
      ace_ready = 1'b0;
      mem_rdata = '0;
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, OP_NONE, '0, '0);

      tbl[0] = '{2'b11, OP_READ,  OP_READ,  0, OP_READ};
      tbl[1] = '{2'b11, OP_READ,  OP_READ,  1, OP_READ};
      tbl[2] = '{2'b11, OP_READ,  OP_READ,  0, OP_READ};
      tbl[3] = '{2'b11, OP_READ,  OP_READ,  1, OP_READ};
      tbl[4] = '{2'b10, OP_NONE,  OP_INVAL, 1, OP_INVAL};
      tbl[5] = '{2'b11, OP_WRITE, OP_READ,  0, OP_WRITE};
      tbl[6] = '{2'b11, OP_NONE,  OP_WRITE, 1, OP_WRITE};
`ifdef ACE_ARB_WB_PRIO_EN
      tbl[7] = '{2'b11, OP_READ,  OP_WRITE, 1, OP_WRITE};
`else
      tbl[7] = '{2'b11, OP_READ,  OP_WRITE, 0, OP_READ};
`endif

      step();
      step();
      #1;
      chk_zero("reset");
      step();
      rst = 1'b0;

      // Table: fairness, invalidate, writes and the write-back priority case.
      for (int i = 0; i < 8; i++) begin
         set_req(0, tbl[i].v[0], tbl[i].op0, 32'h1000_0000 + 32'(i*16), $urandom);
         set_req(1, tbl[i].v[1], tbl[i].op1, 32'h1000_0004 + 32'(i*16), $urandom);
         txn(tbl[i].g, tbl[i].eop, i % 3, 32'hA5A5_0000 + 32'(i), 1'(i % 2), '0);
      end

      // Single read at 0x1000: ace_ready at T+5, response at T+6.
      set_req(0, 1'b1, OP_READ, 32'h0000_1000, 32'h1111_2222);
      set_req(1, 1'b0, OP_NONE, '0, '0);
      txn(0, OP_READ, 3, 32'hDEAD_BEEF, 1'b0, 2'b01);

      // Invalidate with ace_ready held low for 20 cycles.
      set_req(1, 1'b1, OP_INVAL, 32'h0000_2040, 32'h0);
      txn(1, OP_INVAL, 20, 32'h0, 1'b0, 2'b10);

      // Valid with OP_NONE is not a request; ace_ready in IDLE is ignored.
      set_req(0, 1'b1, OP_NONE, 32'h0000_3000, '0);
      set_req(1, 1'b1, OP_NONE, 32'h0000_3004, '0);
      ace_ready = 1'b1;
      #1;
      chk("none_ready", req_ready, 0);
      step();
      ace_ready = 1'b0;
      #1;
      chk("spur_busy", busy, 0);
      chk("spur_resp", resp_valid, 0);
      chk("spur_strobe", {read_req, write_req, invalid_req}, 0);
      step();

      // Withdrawal: req0 drops while req1 is in flight; req1 wins again after.
      set_req(0, 1'b1, OP_READ, 32'h0000_4000, '0);
      set_req(1, 1'b0, OP_NONE, '0, '0);
      txn(0, OP_READ, 1, 32'h4444_0000, 1'b0, 2'b00);
      set_req(1, 1'b1, OP_READ, 32'h0000_4004, '0);
      txn(1, OP_READ, 2, 32'h4444_0001, 1'b0, 2'b01);
      txn(1, OP_READ, 0, 32'h4444_0002, 1'b0, 2'b10);

      // Reset in WAIT with the pointer at 1: afterwards requester 0 wins.
      set_req(0, 1'b1, OP_READ, 32'h0000_5000, '0);
      txn(0, OP_READ, 1, 32'h5555_0000, 1'b0, 2'b00);
      set_req(1, 1'b1, OP_READ, 32'h0000_5004, '0);
      #1;
      chk("pre_rst_ready", req_ready, 2'b10);
      step();
      step();
      rst = 1'b1;
      step();
      #1;
      chk_zero("mid_rst");
      step();
      rst = 1'b0;
      model_ptr = 0;
      txn(0, OP_READ, 2, 32'h5555_0001, 1'b0, 2'b00);

      // Randomized traffic against the reference model.
      for (int i = 0; i < NUM_REQ; i++) rand_req(i);
      for (int it = 0; it < 60; it++) begin
         g = model_pick();
         if (g < 0) begin
            ace_ready = 1'($urandom_range(0, 1));
            #1;
            chk("rand_none_ready", req_ready, 0);
            step();
            ace_ready = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) rand_req(i);
         end else begin
            txn(g, op_a[g], $urandom_range(0, 4), $urandom, 1'($urandom_range(0, 1)), '0);
            rand_req(g);
            for (int i = 0; i < NUM_REQ; i++)
               if (!valid_a[i]) rand_req(i);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ace_req_arbiter.md
# ace_req_arbiter

Shares the single ACE controller between NUM_REQ cache-side requesters, such as I-cache and D-cache miss/writeback engines. It selects one pending request round-robin, registers its opcode, address and write data, and pulses exactly one of read_req/write_req/invalid_req for one cycle. It then waits for ace_ready and returns a one-cycle response, with read data, to the granted requester. It sits between the cache controllers and ace_controller and owns the request-side handshake of that controller.

## Interface
- NUM_REQ, 2: number of requesters, 1..8
- ADDR_W, 32: request address width
- DATA_W, 32: line/word data width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request pending
- req_op  in  2*NUM_REQ  per-requester opcode (ace_op_t)
- req_addr  in  ADDR_W*NUM_REQ  per-requester address
- req_wdata  in  DATA_W*NUM_REQ  per-requester write data
- req_ready  out  NUM_REQ  one-hot accept strobe
- resp_valid  out  NUM_REQ  one-hot completion strobe
- resp_rdata  out  DATA_W  read data for the completing requester
- read_req / write_req / invalid_req  out  1 each  to ACE controller
- ace_ready  in  1  transaction-complete pulse from ACE controller
- mem_addr  out  ADDR_W  registered address to datapath
- mem_wdata  out  DATA_W  registered write data to datapath
- mem_rdata  in  DATA_W  read data from datapath, valid with ace_ready
- busy  out  1  high in any state other than IDLE
- grant_id  out  max(1,$clog2(NUM_REQ))  index of the current owner

## Operation
- A requester i is eligible when req_valid[i]=1 and req_op[i]!=OP_NONE.
- FSM states:
  - IDLE: if any requester is eligible, grant g is the first eligible index at or after rr_ptr, cyclically. req_ready[g]=1 combinationally this cycle. Op, addr and wdata are captured into registers. Next state is ISSUE. With no eligible requester, stay in IDLE.
  - ISSUE: drive exactly one of read_req (OP_READ), write_req (OP_WRITE) or invalid_req (OP_INVAL) high for this cycle only. Next state is WAIT.
  - WAIT: all request strobes are 0. On ace_ready=1, capture mem_rdata into resp_rdata and go to DONE.
  - DONE: resp_valid[g]=1 for one cycle. rr_ptr <= (g==NUM_REQ-1) ? 0 : g+1. Next state is IDLE.
- mem_addr, mem_wdata and grant_id stay stable from ISSUE through DONE.
- resp_rdata holds its value until the next capture. Its value after a write or invalidate is don't-care.
- A requester may drop req_valid before it is granted; nothing is latched for it.
- A requester must hold its op/addr/wdata until it sees req_ready.
- An ace_ready seen in IDLE, ISSUE or DONE is ignored.
- NUM_REQ=1: rr_ptr is constant 0.

## Timing
- Reset values: state=IDLE, rr_ptr=0, and every output 0: req_ready, resp_valid, resp_rdata, read/write/invalid_req, mem_addr, mem_wdata, busy, grant_id.
- Latency: the accept cycle is T. The request strobe fires at T+1. resp_valid is asserted one cycle after the ace_ready cycle.
- Minimum back-to-back spacing: a new accept is possible in the cycle after DONE.
- Request strobes are one-cycle pulses by construction. This prevents the ACE controller from re-launching when it returns to its idle state.
- Reset asserted mid-transaction: the FSM goes to IDLE on the next edge and any pending resp_valid is lost. The ACE controller is reset in the same cycle.

## Configuration
- Macro: ACE_ARB_WB_PRIO_EN.
- When defined, eligible requesters with OP_WRITE win first. The round-robin from rr_ptr runs among writers only. If no writer is eligible, it runs among all eligible requesters. rr_ptr update is unchanged.
- When not defined, pure round-robin is used and the opcode is ignored for selection.

## Structure
- Package ace_arb_pkg:
  - ace_op_t enum: OP_NONE=2'b00, OP_READ=2'b01, OP_WRITE=2'b10, OP_INVAL=2'b11.
  - arb_state_t enum: IDLE, ISSUE, WAIT, DONE.
- Sub-module rr_pick: purely combinational. It takes a request vector and a pointer and returns a one-hot grant plus an index. It is instantiated once, or twice under ACE_ARB_WB_PRIO_EN (writer mask, then all).

## Test plan
- Single read: requester 0 issues OP_READ at addr 0x1000. Expect req_ready[0] at T, read_req pulsed at T+1 only, and mem_addr=0x1000. ace_ready comes at T+5 with mem_rdata=0xDEADBEEF. Expect resp_valid[0] at T+6 with resp_rdata=0xDEADBEEF.
- Fairness: both requesters hold OP_READ continuously. Grants must alternate 0,1,0,1 across 4 transactions, and rr_ptr must wrap from 1 to 0.
- Write-back priority: req0 issues OP_READ and req1 issues OP_WRITE, with rr_ptr=0.
  - With ACE_ARB_WB_PRIO_EN: req1 is granted and write_req pulses.
  - Without it: req0 is granted and read_req pulses.
- Invalidate with ace_ready stuck low for 20 cycles: invalid_req pulses once, then busy=1 and no strobes for 20 cycles. After ace_ready, resp_valid goes to the granted requester only.
- Reset asserted in WAIT: on the next edge all outputs are 0 and the state is IDLE. A fresh request is accepted in the cycle after reset deasserts.
- Withdrawal and noise: req_valid=1 with OP_NONE must produce no grant. req0 dropping req_valid while req1 is in WAIT must produce no grant for req0 after DONE. A spurious ace_ready in IDLE must be ignored.
